tnoc_flit_generator: RTL
========================

TNOC_FLIT_GENERATOR -- requirements
Module: tnoc_flit_generator

Interface
REQ-001 SHALL have parameter CONFIG: default TNOC_DEFAULT_CONFIG; NoC configuration (channels, VCs, flit width).
REQ-002 SHALL have parameter PORT_TYPE: default TNOC_LOCAL_PORT; port type of flit_out_if.
REQ-003 SHALL have parameter PAYLOAD_SEED: default 32'h0000_0001; payload value of the first flit after reset.
REQ-004 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1, one-cycle request to send one packet.
REQ-007 SHALL have port i_length, input, 8, flits per packet; sampled with i_start.
REQ-008 SHALL have port i_vc, input, log2(VCS), virtual channel; sampled with i_start.
REQ-009 SHALL have port o_busy, output, 1, high from accepted start until the tail flit handshake.
REQ-010 SHALL have port o_packet_count, output, 16, number of packets completed.
REQ-011 SHALL have port flit_out_if, tnoc_flit_if.initiator, -, flit stream out (valid, ready, flit, vc_available).

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT_VC and SEND.
REQ-013 In IDLE, i_start SHALL latch i_length and i_vc and go to WAIT_VC; o_busy rises the next cycle.
REQ-014 i_start while o_busy=1 SHALL be ignored (no queuing).
REQ-015 i_length=0 SHALL be treated as 1.
REQ-016 WAIT_VC SHALL go to SEND on the first cycle vc_available[latched vc]=1.
REQ-017 While in WAIT_VC, valid SHALL stay 0.
REQ-018 In SEND, valid[latched vc] SHALL be 1 and all other valid bits 0.
REQ-019 A flit transfers on a cycle with valid=1 and ready=1.
REQ-020 Valid=1 with ready=0 SHALL hold flit content and valid unchanged (no retraction).
REQ-021 Flit fields: head=1 on flit 0 only; tail=1 on flit length-1 only; a single-flit packet has head=tail=1; vc=latched vc; payload=32-bit payload counter.
REQ-022 The payload counter SHALL start at PAYLOAD_SEED, increment by 1 per transferred flit, and wrap 32'hFFFF_FFFF -> 0.
REQ-023 The flit index counter SHALL be 8 bits, reset to 0 at each start.
REQ-024 On the tail transfer, the FSM SHALL go to IDLE, o_busy SHALL fall, and o_packet_count SHALL increment in the same edge (wraps 16'hFFFF -> 0).
REQ-025 Back-to-back: i_start in the first IDLE cycle after a tail SHALL be accepted.
REQ-026 Minimum gap between packets SHALL be 2 cycles (IDLE, WAIT_VC).
REQ-027 vc_available is checked only before the head; its deassertion mid-packet SHALL NOT stall or abort the packet.
REQ-028 ready on channels/VCs other than the latched vc SHALL be ignored.

Reset
REQ-029 While i_rst_n=0: FSM=IDLE; all valid=0; flit fields=0; o_busy=0; o_packet_count=0; payload counter=PAYLOAD_SEED; index=0.
REQ-030 Reset asserted mid-packet SHALL abort the packet immediately (valid=0 asynchronously), with no tail emitted.
REQ-031 The first cycle after reset release SHALL accept i_start.

Verification
REQ-032 i_start, length=1, vc=0, ready=1, vc_available=1 -> one flit head=1 tail=1 payload=1 two cycles later; o_packet_count=1.
REQ-033 length=4, ready toggled 1,0,0,1,... -> 4 flits, payload 1..4, content stable during ready=0, head only on first, tail only on fourth.
REQ-034 vc_available[1]=0 for 10 cycles after i_start with vc=1 -> valid stays 0 for those cycles; head appears the cycle after availability rises.
REQ-035 Second i_start during busy -> ignored; o_packet_count increments once.
REQ-036 PAYLOAD_SEED=32'hFFFF_FFFE, length=3 -> payloads FFFF_FFFE, FFFF_FFFF, 0000_0000.
REQ-037 i_rst_n low during the second flit of a length-4 packet -> valid=0 immediately, o_busy=0, o_packet_count=0; after release, a new packet starts with payload=PAYLOAD_SEED.

Source files
------------

// File: rtl/tnoc_flit_generator_if.sv
// NoC configuration package and flit stream interface.
// Shared by the flit generator and its neighbours.
package tnoc_pkg;
  typedef struct packed {
    int vcs;
  } tnoc_config_t;

  localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{vcs: 2};

  typedef enum logic [0:0] {
    TNOC_LOCAL_PORT,
    TNOC_INTERNAL_PORT
  } tnoc_port_type_t;

  localparam int TNOC_VC_FIELD_W = 4;
  localparam int TNOC_PAYLOAD_W  = 32;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [TNOC_VC_FIELD_W-1:0] vc;
    logic [TNOC_PAYLOAD_W-1:0]  payload;
  } tnoc_flit_t;
endpackage

interface tnoc_flit_if
  import tnoc_pkg::*;
#(
  parameter tnoc_config_t CONFIG = TNOC_DEFAULT_CONFIG
) ();
  logic [CONFIG.vcs-1:0] valid;
  logic [CONFIG.vcs-1:0] ready;
  logic [CONFIG.vcs-1:0] vc_available;
  tnoc_flit_t            flit;

  modport initiator (
    output valid,
    input  ready,
    output flit,
    input  vc_available
  );

  modport target (
    input  valid,
    output ready,
    input  flit,
    output vc_available
  );
endinterface

// File: rtl/tnoc_flit_generator.sv
// Packet source: emits one packet of i_length flits per start
// request on the latched VC once that VC reports availability.
module tnoc_flit_generator
  import tnoc_pkg::*;
#(
  parameter tnoc_config_t    CONFIG       = TNOC_DEFAULT_CONFIG,
  parameter tnoc_port_type_t PORT_TYPE    = TNOC_LOCAL_PORT,
  parameter logic [31:0]     PAYLOAD_SEED = 32'h0000_0001,
  localparam int VCS = CONFIG.vcs,
  localparam int VCW = (VCS > 1) ? $clog2(VCS) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [7:0]     i_length,
  input  logic [VCW-1:0] i_vc,
  output logic           o_busy,
  output logic [15:0]    o_packet_count,
  tnoc_flit_if.initiator flit_out_if
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT_VC,
    SEND
  } state_t;

  state_t         r_state;
  logic [7:0]     r_len;
  logic [7:0]     r_idx;
  logic [VCW-1:0] r_vc;
  logic [31:0]    r_payload;
  logic [VCS-1:0] r_valid;
  tnoc_flit_t     r_flit;
  logic           r_busy;
  logic [15:0]    r_count;

  logic           w_port_ok;
  logic           w_vc_go;
  logic           w_xfer;
  logic [7:0]     w_idx_nxt;
  logic [7:0]     w_len_in;
  logic [VCS-1:0] w_onehot;

  assign w_port_ok = (PORT_TYPE == TNOC_LOCAL_PORT) ||
                     (PORT_TYPE == TNOC_INTERNAL_PORT);
  assign w_vc_go   = flit_out_if.vc_available[r_vc] & w_port_ok;
  assign w_xfer    = r_valid[r_vc] & flit_out_if.ready[r_vc];
  assign w_idx_nxt = r_idx + 8'd1;
  assign w_len_in  = (i_length == 8'd0) ? 8'd1 : i_length;

  always_comb begin
    w_onehot       = '0;
    w_onehot[r_vc] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_len     <= 8'd0;
      r_idx     <= 8'd0;
      r_vc      <= '0;
      r_payload <= PAYLOAD_SEED;
      r_valid   <= '0;
      r_flit    <= '0;
      r_busy    <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len   <= w_len_in;
            r_vc    <= i_vc;
            r_idx   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= WAIT_VC;
          end
        end
        WAIT_VC: begin
          if (w_vc_go) begin
            r_state        <= SEND;
            r_valid        <= w_onehot;
            r_flit.head    <= 1'b1;
            r_flit.tail    <= (r_len == 8'd1);
            r_flit.vc      <= TNOC_VC_FIELD_W'(r_vc);
            r_flit.payload <= r_payload;
          end
        end
        SEND: begin
          if (w_xfer) begin
            r_payload <= r_payload + 32'd1;
            if (r_flit.tail) begin
              r_state <= IDLE;
              r_valid <= '0;
              r_flit  <= '0;
              r_busy  <= 1'b0;
              r_count <= r_count + 16'd1;
            end else begin
              r_idx          <= w_idx_nxt;
              r_flit.head    <= 1'b0;
              r_flit.tail    <= (w_idx_nxt == r_len - 8'd1);
              r_flit.payload <= r_payload + 32'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flit_out_if.valid = r_valid;
  assign flit_out_if.flit  = r_flit;
  assign o_busy            = r_busy;
  assign o_packet_count    = r_count;
endmodule
